// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and helpers for the RV32I load/store unit:
//               funct3 codes, FSM state type and request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  // Access FSM states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // True when funct3 names a real load (ld=1) or store (ld=0) encoding
  function automatic logic lsu_funct3_legal(input logic ld, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (ld) begin
      case (f3)
        LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU: ok = 1'b1;
        default:                                  ok = 1'b0;
      endcase
    end else begin
      case (f3)
        LSU_SB, LSU_SH, LSU_SW: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Core-side request/response and data-memory bus bundle of the
//               load/store unit. 'master' is the LSU view (it masters the
//               memory bus); 'slave' is the environment (core + memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if;

  // Core request
  logic        valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;

  // Core response
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;

  // Data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  valid, is_load, is_store, funct3, addr, store_data,
    input  mem_ready, mem_rdata,
    output stall, done, load_data, misaligned,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output valid, is_load, is_store, funct3, addr, store_data,
    output mem_ready, mem_rdata,
    input  stall, done, load_data, misaligned,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic: natural-alignment check,
//               store lane replication / byte strobes, and load lane
//               extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic        aligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Natural alignment; store codes share the load encodings for width
  always_comb begin
    aligned_o = 1'b0;
    case (funct3_i)
      LSU_LB, LSU_LBU: aligned_o = 1'b1;
      LSU_LH, LSU_LHU: aligned_o = ~addr_lo_i[0];
      LSU_LW:          aligned_o = (addr_lo_i == 2'b00);
      default:         aligned_o = 1'b0;
    endcase
  end

  // Store data replicated to every lane; strobes select the addressed lane(s)
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    case (funct3_i)
      LSU_SB: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      LSU_SH: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      LSU_SW: begin
        wdata_o = store_data_i;
        wstrb_o = 4'b1111;
      end
      default: begin
        wdata_o = 32'h0;
        wstrb_o = 4'b0000;
      end
    endcase
  end

  // Pick the byte and halfword lanes named by the latched offset
  always_comb begin
    w_byte = rdata_i[7:0];
    case (ld_off_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend the selected lane to 32 bits
  always_comb begin
    load_data_o = 32'h0;
    case (ld_funct3_i)
      LSU_LB:  load_data_o = {{24{w_byte[7]}}, w_byte};
      LSU_LH:  load_data_o = {{16{w_half[15]}}, w_half};
      LSU_LW:  load_data_o = rdata_i;
      LSU_LBU: load_data_o = {24'h0, w_byte};
      LSU_LHU: load_data_o = {16'h0, w_half};
      default: load_data_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : RV32I load/store unit. Accepts one aligned memory op from the
//               execute stage, runs it on a req/ready data bus, stalls the
//               core until completion and returns extended load data.
//               Misaligned requests raise a one-cycle flag with no access.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.master bus
);

  lsu_state_e  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        done_q;
  logic        misaligned_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;

  logic        w_req_ok;
  logic        w_aligned;
  logic        w_accept;
  logic        w_misalign;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  lsu_align u_align (
    .funct3_i     (bus.funct3),
    .addr_lo_i    (bus.addr[1:0]),
    .store_data_i (bus.store_data),
    .aligned_o    (w_aligned),
    .wstrb_o      (w_wstrb),
    .wdata_o      (w_wdata),
    .ld_funct3_i  (ld_funct3_q),
    .ld_off_i     (ld_off_q),
    .rdata_i      (bus.mem_rdata),
    .load_data_o  (w_load_data)
  );

  // Well-formed request: exactly one of load/store with a legal funct3
  assign w_req_ok   = bus.valid & (bus.is_load ^ bus.is_store)
                    & lsu_funct3_legal(bus.is_load, bus.funct3);
  assign w_accept   = w_req_ok & w_aligned;
  assign w_misalign = w_req_ok & ~w_aligned;

  // Freeze the core from the accepting cycle through the end of BUSY
  assign bus.stall = rst_n & (((state_q == LSU_IDLE) & w_accept) | (state_q == LSU_BUSY));

  assign bus.done       = done_q;
  assign bus.load_data  = load_data_q;
  assign bus.misaligned = misaligned_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // Access FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      ld_funct3_q  <= 3'b000;
      ld_off_q     <= 2'b00;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (w_accept) begin
            state_q     <= LSU_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.is_store;
            mem_addr_q  <= {bus.addr[31:2], 2'b00};
            mem_wstrb_q <= bus.is_store ? w_wstrb : 4'b0000;
            mem_wdata_q <= bus.is_store ? w_wdata : 32'h0;
            ld_funct3_q <= bus.funct3;
            ld_off_q    <= bus.addr[1:0];
          end else if (w_misalign) begin
            misaligned_q <= 1'b1;
          end
        end
        LSU_BUSY: begin
          if (bus.mem_ready) begin
            state_q   <= LSU_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (!mem_we_q) begin
              load_data_q <= w_load_data;
            end
          end
        end
        LSU_DONE: begin
          state_q <= LSU_IDLE;
        end
        default: begin
          state_q <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lsu_if bus ();

  lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid      = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    bus.mem_ready  = 1'b0;
  endtask

  // One accepted access; the request is held until the DONE edge
  task automatic access(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic [31:0] e_addr, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [31:0] e_load);
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.is_load = ld; bus.is_store = st; bus.funct3 = f3;
    bus.addr = a; bus.store_data = sd; bus.mem_rdata = rd; bus.mem_ready = 1'b0;
    @(negedge clk);
    check({tag, " stall@T"}, bus.stall, 1);
    check({tag, " req@T"}, bus.mem_req, 0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      bus.mem_ready = (i == waits);
      @(negedge clk);
      check({tag, " stall busy"}, bus.stall, 1);
      check({tag, " req busy"}, bus.mem_req, 1);
      check({tag, " done busy"}, bus.done, 0);
      check({tag, " addr"}, bus.mem_addr, e_addr);
      check({tag, " wstrb"}, bus.mem_wstrb, e_strb);
      check({tag, " we"}, bus.mem_we, st);
      if (st) check({tag, " wdata"}, bus.mem_wdata, e_wdata);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check({tag, " done"}, bus.done, 1);
    check({tag, " stall done"}, bus.stall, 0);
    check({tag, " req done"}, bus.mem_req, 0);
    check({tag, " load_data"}, bus.load_data, e_load);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({tag, " done clr"}, bus.done, 0);
    check({tag, " stall idle"}, bus.stall, 0);
  endtask

  // One-cycle request that must not start an access
  task automatic reject(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic e_mis);
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.is_load = ld; bus.is_store = st; bus.funct3 = f3;
    bus.addr = a; bus.store_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check({tag, " stall"}, bus.stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({tag, " misaligned"}, bus.misaligned, e_mis);
    check({tag, " req"}, bus.mem_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " mis clr"}, bus.misaligned, 0);
    check({tag, " req after"}, bus.mem_req, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.mem_rdata = 32'h0;
    idle_inputs();
    // An otherwise valid SW during reset must not stall
    bus.valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h0000_0040; bus.store_data = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    check("rst stall", bus.stall, 0);
    check("rst req", bus.mem_req, 0);
    check("rst we", bus.mem_we, 0);
    check("rst addr", bus.mem_addr, 0);
    check("rst wstrb", bus.mem_wstrb, 0);
    check("rst wdata", bus.mem_wdata, 0);
    check("rst load_data", bus.load_data, 0);
    check("rst done", bus.done, 0);
    check("rst misaligned", bus.misaligned, 0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;

    access("SW",  1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0,
           32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access("SB",  1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0,
           32'h0000_0010, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access("LB",  1'b1, 1'b0, 3'b000, 32'h0000_0022, 32'h0, 32'h1280_7F00, 0,
           32'h0000_0020, 4'b0000, 32'h0, 32'hFFFF_FF80);
    access("LBU", 1'b1, 1'b0, 3'b100, 32'h0000_0022, 32'h0, 32'h1280_7F00, 0,
           32'h0000_0020, 4'b0000, 32'h0, 32'h0000_0080);
    access("LH",  1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_0000, 3,
           32'h0000_0040, 4'b0000, 32'h0, 32'hFFFF_8001);
    access("LHU", 1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h8001_0000, 1,
           32'h0000_0040, 4'b0000, 32'h0, 32'h0000_8001);
    access("LB0", 1'b1, 1'b0, 3'b000, 32'h0000_0031, 32'h0, 32'h0000_7F00, 0,
           32'h0000_0030, 4'b0000, 32'h0, 32'h0000_007F);
    access("LW",  1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 0,
           32'h0000_0008, 4'b0000, 32'h0, 32'hCAFE_F00D);
    // Store keeps the last load result
    access("SH",  1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h5555_5555, 2,
           32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'hCAFE_F00D);

    reject("LWmis",  1'b1, 1'b0, 3'b010, 32'h0000_0006, 1'b1);
    reject("SHmis",  1'b0, 1'b1, 3'b001, 32'h0000_0009, 1'b1);
    reject("LHmis",  1'b1, 1'b0, 3'b101, 32'h0000_0003, 1'b1);
    reject("LDST",   1'b1, 1'b1, 3'b010, 32'h0000_0008, 1'b0);
    reject("LDf3",   1'b1, 1'b0, 3'b011, 32'h0000_0008, 1'b0);
    reject("STf3",   1'b0, 1'b1, 3'b100, 32'h0000_0008, 1'b0);

    // Reset in the middle of a BUSY load
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.is_load = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h0000_0100; bus.mem_rdata = 32'hAAAA_BBBB;
    @(negedge clk);
    check("RST stall@T", bus.stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("RST req busy", bus.mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("RST stall forced", bus.stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("RST req cleared", bus.mem_req, 0);
    check("RST no done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("RST no done later", bus.done, 0);
    check("RST idle stall", bus.stall, 0);

    access("LWpost", 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, 0,
           32'h0000_0200, 4'b0000, 32'h0, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
